// File: rtl/seven_seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan display path.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [1:0] digit_idx_t;

  localparam seg_t        SEG_BLANK = 7'h7F;
  localparam seg_t        SEG_E     = 7'h06;
  localparam logic [15:0] ERR_CODE  = 16'hEEEE;

  // Active-low one-hot anode pattern for the selected digit.
  function automatic logic [3:0] an_onehot_low(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seven_seg_scan_bcd_to_7seg.sv
// Combinational BCD nibble to active-low gfedcba decoder; 0xE decodes to 'E',
// other non-decimal codes and the blank flag produce an unlit digit.
module bcd_to_7seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (nibble_i)
        4'h0:    seg_o = 7'h40;
        4'h1:    seg_o = 7'h79;
        4'h2:    seg_o = 7'h24;
        4'h3:    seg_o = 7'h30;
        4'h4:    seg_o = 7'h19;
        4'h5:    seg_o = 7'h12;
        4'h6:    seg_o = 7'h02;
        4'h7:    seg_o = 7'h78;
        4'h8:    seg_o = 7'h00;
        4'h9:    seg_o = 7'h10;
        4'hE:    seg_o = SEG_E;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit common-anode seven-segment scanner with frame-shadowed BCD input.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros on digits 3..1.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_PERIOD = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        en,
  output logic [3:0]  an,
  output seg_t        seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int TICK_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_PERIOD - 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  digit_idx_t        idx_q, idx_d;
  logic [15:0]       shadow_bcd_q, shadow_bcd_d;
  logic [3:0]        shadow_dp_q, shadow_dp_d;
  logic [3:0]        an_q, an_d;
  seg_t              seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              frame_done_q, frame_done_d;

  logic              terminal;
  logic              boundary;
  logic              err;
  logic [3:0]        cur_nibble;
  logic              cur_blank;
  seg_t              dec_seg;

  // Scan timing and frame-boundary shadow capture
  always_comb begin
    terminal     = (tick_q == TICK_LAST);
    boundary     = terminal && (idx_q == 2'd3);
    tick_d       = terminal ? '0 : tick_q + 1'b1;
    idx_d        = terminal ? idx_q + 1'b1 : idx_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    if (boundary) begin
      shadow_bcd_d = bcd_in;
      shadow_dp_d  = dp_in;
    end
    frame_done_d = boundary;
  end

  // Digit selection and blanking for the currently scanned position
  always_comb begin
    err        = (shadow_bcd_q == ERR_CODE);
    cur_nibble = shadow_bcd_q[3:0];
    cur_blank  = 1'b0;
    case (idx_q)
      2'd0: cur_nibble = shadow_bcd_q[3:0];
      2'd1: cur_nibble = shadow_bcd_q[7:4];
      2'd2: cur_nibble = shadow_bcd_q[11:8];
      2'd3: cur_nibble = shadow_bcd_q[15:12];
      default: cur_nibble = shadow_bcd_q[3:0];
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_q)
      2'd3:    cur_blank = (shadow_bcd_q[15:12] == 4'h0);
      2'd2:    cur_blank = (shadow_bcd_q[15:8] == 8'h00);
      2'd1:    cur_blank = (shadow_bcd_q[15:4] == 12'h000);
      default: cur_blank = 1'b0;
    endcase
    // The overflow code must always read "EEEE", never partially blanked.
    if (err) cur_blank = 1'b0;
`else
    cur_blank = 1'b0;
`endif
  end

  bcd_to_7seg u_dec (
    .nibble_i (cur_nibble),
    .blank_i  (cur_blank),
    .seg_o    (dec_seg)
  );

  // Registered display outputs, one cycle behind the scan index
  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (en) begin
      an_d  = an_onehot_low(idx_q);
      seg_d = err ? SEG_E : dec_seg;
      dp_d  = ~shadow_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q       <= '0;
      idx_q        <= '0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      an_q         <= 4'b1111;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with DIGIT_PERIOD=4 (16-cycle frames).
module tb_seven_seg_scan;

  logic        clk;
  logic        reset;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_checks;
  int n_fail;
  int n;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZHI = 7'h7F;
`else
  localparam logic [6:0] ZHI = 7'h40;
`endif

  logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] exp_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
  logic       exp_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  seven_seg_scan #(.DIGIT_PERIOD(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .en         (en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  // Advance to edge number target since the last reset release, sampling 1 time unit after it.
  task automatic step_to(input int target);
    while (n < target) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n        = 0;
    reset    = 1'b1;
    en       = 1'b1;
    bcd_in   = 16'h0000;
    dp_in    = 4'b0000;

    // Reset clears outputs with no clock edge
    #1 reset = 1'b0;
    #1;
    check_eq("rst_an", an, 4'b1111);
    check_eq("rst_seg", seg, 7'h7F);
    check_eq("rst_dp", dp, 1'b1);
    check_eq("rst_fd", frame_done, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b1;
    bcd_in = 16'h1234;
    dp_in  = 4'b0100;
    n      = 0;

    step_to(1);
    check_eq("f1_d0_an", an, 4'b1110);
    check_eq("f1_d0_seg", seg, 7'h40);
    step_to(5);
    check_eq("f1_d1_an", an, 4'b1101);
    check_eq("f1_d1_seg", seg, ZHI);

    // Reset mid-scan, held for three cycles
    step_to(6);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_an", an, 4'b1111);
    check_eq("mid_rst_seg", seg, 7'h7F);
    check_eq("mid_rst_dp", dp, 1'b1);
    check_eq("mid_rst_fd", frame_done, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("held_rst_an", an, 4'b1111);
    reset = 1'b1;
    n     = 0;
    step_to(1);
    check_eq("rel_an", an, 4'b1110);
    check_eq("rel_seg", seg, 7'h40);

    step_to(15);
    check_eq("fd_pre", frame_done, 1'b0);
    step_to(16);
    check_eq("fd_f1", frame_done, 1'b1);
    check_eq("f1_d3_an", an, 4'b0111);
    check_eq("f1_d3_seg", seg, ZHI);

    // Frame 2 shows 1234 with dp on digit 2
    for (int c = 17; c <= 32; c++) begin
      int k;
      step_to(c);
      k = (c - 17) / 4;
      check_eq("f2_an", an, exp_an[k]);
      check_eq("f2_seg", seg, exp_seg[k]);
      check_eq("f2_dp", dp, exp_dp[k]);
      check_eq("f2_fd", frame_done, (c == 32) ? 1'b1 : 1'b0);
    end

    // Input change mid-frame must wait for the boundary
    step_to(37);
    check_eq("f3_d1_seg", seg, 7'h30);
    bcd_in = 16'h5678;
    step_to(41);
    check_eq("tear_d2", seg, 7'h24);
    step_to(45);
    check_eq("tear_d3", seg, 7'h79);
    step_to(48);
    check_eq("fd_f3", frame_done, 1'b1);
    step_to(49);
    check_eq("f4_d0_an", an, 4'b1110);
    check_eq("f4_d0", seg, 7'h00);
    step_to(53);
    check_eq("f4_d1", seg, 7'h78);
    step_to(57);
    check_eq("f4_d2", seg, 7'h02);
    step_to(61);
    check_eq("f4_d3", seg, 7'h12);

    // Value applied just before the boundary edge is captured
    step_to(63);
    bcd_in = 16'hEEEE;
    step_to(65);
    check_eq("err_d0", seg, 7'h06);
    step_to(69);
    check_eq("err_d1", seg, 7'h06);
    step_to(73);
    check_eq("err_d2", seg, 7'h06);
    step_to(77);
    check_eq("err_d3", seg, 7'h06);

    step_to(78);
    bcd_in = 16'h0042;
    step_to(81);
    check_eq("z42_d0", seg, 7'h24);
    step_to(85);
    check_eq("z42_d1", seg, 7'h19);
    step_to(89);
    check_eq("z42_d2", seg, ZHI);
    check_eq("z42_d2_an", an, 4'b1011);
    check_eq("z42_d2_dp", dp, 1'b0);
    step_to(93);
    check_eq("z42_d3", seg, ZHI);

    step_to(94);
    bcd_in = 16'h0000;
    step_to(97);
    check_eq("z0_d0", seg, 7'h40);
    step_to(101);
    check_eq("z0_d1", seg, ZHI);
    step_to(105);
    check_eq("z0_d2", seg, ZHI);
    step_to(109);
    check_eq("z0_d3", seg, ZHI);
    check_eq("z0_d3_an", an, 4'b0111);

    // Display disable keeps the scan running underneath
    step_to(110);
    bcd_in = 16'h1234;
    step_to(113);
    check_eq("en_pre_an", an, 4'b1110);
    check_eq("en_pre_seg", seg, 7'h19);
    step_to(114);
    en = 1'b0;
    step_to(115);
    check_eq("en0_an", an, 4'b1111);
    check_eq("en0_seg", seg, 7'h7F);
    check_eq("en0_dp", dp, 1'b1);
    step_to(124);
    check_eq("en0_hold_an", an, 4'b1111);
    en = 1'b1;
    step_to(125);
    check_eq("en1_an", an, 4'b0111);
    check_eq("en1_seg", seg, 7'h79);
    step_to(128);
    check_eq("en1_fd", frame_done, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
